// File: rtl/or_layer_seq.sv
// ----------------------------------------------------------------------------
// or_layer_seq
//   Per-layer sequencer for the output regfile. Steps through the network one
//   layer at a time, presents that layer's pooling size P and stride S, and
//   drives the or_cs state code the regfile uses to gate its read-address
//   advance (4) and its per-layer reset (8). Regfile output windows are counted
//   so a layer is only closed once all of its windows have drained.
//
// Ports
//   clk_cal       in   calculation clock
//   rst_cal       in   asynchronous reset, active-high
//   start         in   1-cycle pulse, run the whole network (IDLE only)
//   pe_done       in   1-cycle pulse, PE array finished the current layer
//   or_odata_vld  in   regfile output window valid
//   or_cs         out  [5:0] state code: 0 idle, 1 load, 4 cal, 8 layer end, 9 done
//   P             out  [2:0] current layer pooling size
//   S             out  [1:0] current layer stride
//   layer_idx     out  [2:0] current layer index, 0-based
//   layer_done    out  1-cycle pulse in the layer-end cycle
//   net_done      out  1-cycle pulse in the done cycle
//   busy          out  high whenever not idle
//   ovf_err       out  sticky: a window arrived that could not be counted
// ----------------------------------------------------------------------------
module or_layer_seq #(
   parameter int                        NUM_LAYERS = 6,
   parameter logic [3*NUM_LAYERS-1:0]   P_TABLE    = 18'h12967,
   parameter logic [2*NUM_LAYERS-1:0]   S_TABLE    = 12'hAAA,
   parameter logic [8*NUM_LAYERS-1:0]   WIN_TABLE  = 48'h101010101010
) (
   input  logic       clk_cal,
   input  logic       rst_cal,
   input  logic       start,
   input  logic       pe_done,
   input  logic       or_odata_vld,
   output logic [5:0] or_cs,
   output logic [2:0] P,
   output logic [1:0] S,
   output logic [2:0] layer_idx,
   output logic       layer_done,
   output logic       net_done,
   output logic       busy,
   output logic       ovf_err
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CAL,
      ST_DRAIN,
      ST_LEND,
      ST_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  layer_q, layer_d;
   logic [2:0]  p_q, p_d;
   logic [1:0]  s_q, s_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        ovf_q, ovf_d;
   logic [5:0]  cs_q;
   logic        ld_q, nd_q, busy_q;

   logic [7:0]  win_tgt;
   logic        cnt_full;

   // Table lookups use shifts so the index width never has to match the table.
   function automatic logic [2:0] p_lookup(input logic [2:0] idx);
      logic [3*NUM_LAYERS-1:0] sh;
      sh = P_TABLE >> (3 * idx);
      return sh[2:0];
   endfunction

   function automatic logic [1:0] s_lookup(input logic [2:0] idx);
      logic [2*NUM_LAYERS-1:0] sh;
      sh = S_TABLE >> (2 * idx);
      return sh[1:0];
   endfunction

   function automatic logic [7:0] win_lookup(input logic [2:0] idx);
      logic [8*NUM_LAYERS-1:0] sh;
      sh = WIN_TABLE >> (8 * idx);
      return sh[7:0];
   endfunction

   // CAL and DRAIN share code 4 so the regfile keeps advancing while draining.
   function automatic logic [5:0] cs_code(input state_t st);
      case (st)
         ST_IDLE:  return 6'd0;
         ST_LOAD:  return 6'd1;
         ST_CAL:   return 6'd4;
         ST_DRAIN: return 6'd4;
         ST_LEND:  return 6'd8;
         ST_DONE:  return 6'd9;
         default:  return 6'd0;
      endcase
   endfunction

   assign win_tgt  = win_lookup(layer_q);
   assign cnt_full = (cnt_q == win_tgt);

   always_comb begin
      state_d = state_q;
      layer_d = layer_q;
      p_d     = p_q;
      s_d     = s_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;

      case (state_q)
         ST_IDLE: begin
            if (or_odata_vld) ovf_d = 1'b1;
            // A new run clears the sticky error, overriding a stray window.
            if (start) begin
               state_d = ST_LOAD;
               layer_d = 3'd0;
               ovf_d   = 1'b0;
               p_d     = p_lookup(3'd0);
               s_d     = s_lookup(3'd0);
               cnt_d   = 8'd0;
            end
         end

         ST_LOAD: begin
            if (or_odata_vld) ovf_d = 1'b1;
            state_d = ST_CAL;
         end

         ST_CAL: begin
            // Windows may arrive before pe_done; a window in the pe_done
            // cycle still counts.
            if (or_odata_vld) begin
               if (cnt_full) ovf_d = 1'b1;
               else          cnt_d = cnt_q + 8'd1;
            end
            if (pe_done) state_d = ST_DRAIN;
         end

         ST_DRAIN: begin
            if (cnt_full) begin
               if (or_odata_vld) ovf_d = 1'b1;
               state_d = ST_LEND;
            end else if (or_odata_vld) begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         ST_LEND: begin
            if (or_odata_vld) ovf_d = 1'b1;
            if (layer_q == 3'(NUM_LAYERS - 1)) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_LOAD;
               layer_d = layer_q + 3'd1;
               p_d     = p_lookup(layer_q + 3'd1);
               s_d     = s_lookup(layer_q + 3'd1);
               cnt_d   = 8'd0;
            end
         end

         ST_DONE: begin
            if (or_odata_vld) ovf_d = 1'b1;
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk_cal or posedge rst_cal) begin
      if (rst_cal) begin
         state_q <= ST_IDLE;
         layer_q <= 3'd0;
         p_q     <= 3'd0;
         s_q     <= 2'd0;
         cnt_q   <= 8'd0;
         ovf_q   <= 1'b0;
         cs_q    <= 6'd0;
         ld_q    <= 1'b0;
         nd_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         layer_q <= layer_d;
         p_q     <= p_d;
         s_q     <= s_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         cs_q    <= cs_code(state_d);
         ld_q    <= (state_d == ST_LEND);
         nd_q    <= (state_d == ST_DONE);
         busy_q  <= (state_d != ST_IDLE);
      end
   end

   assign or_cs      = cs_q;
   assign P          = p_q;
   assign S          = s_q;
   assign layer_idx  = layer_q;
   assign layer_done = ld_q;
   assign net_done   = nd_q;
   assign busy       = busy_q;
   assign ovf_err    = ovf_q;

endmodule

// File: tb/tb_or_layer_seq.sv
module tb_or_layer_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic start0, pe0, vld0, start1, pe1, vld1;
   logic [5:0] cs0, cs1;
   logic [2:0] p0, p1, idx0, idx1;
   logic [1:0] s0, s1;
   logic ld0, ld1, nd0, nd1, busy0, busy1, ovf0, ovf1;

   or_layer_seq dut0 (
      .clk_cal(clk), .rst_cal(rst), .start(start0), .pe_done(pe0),
      .or_odata_vld(vld0), .or_cs(cs0), .P(p0), .S(s0), .layer_idx(idx0),
      .layer_done(ld0), .net_done(nd0), .busy(busy0), .ovf_err(ovf0)
   );

   or_layer_seq #(
      .NUM_LAYERS(1), .P_TABLE(3'd7), .S_TABLE(2'd2), .WIN_TABLE(8'd16)
   ) dut1 (
      .clk_cal(clk), .rst_cal(rst), .start(start1), .pe_done(pe1),
      .or_odata_vld(vld1), .or_cs(cs1), .P(p1), .S(s1), .layer_idx(idx1),
      .layer_done(ld1), .net_done(nd1), .busy(busy1), .ovf_err(ovf1)
   );

   // ---------------- behavioural model ----------------
   localparam int PH_IDLE = 0, PH_LOAD = 1, PH_CAL = 2, PH_DRAIN = 3, PH_LEND = 4, PH_DONE = 5;

   typedef struct {
      int ph;
      int cnt;
      int idx;
      int P;
      int S;
      bit ovf;
   } mst_t;

   mst_t ma, mb;

   function automatic int layers(int k);
      return (k == 0) ? 6 : 1;
   endfunction

   function automatic int p_of(int k, int l);
      longint t = 64'h12967;
      return (k == 0) ? int'((t >> (3 * l)) & 64'h7) : 7;
   endfunction

   function automatic int s_of(int k, int l);
      longint t = 64'hAAA;
      return (k == 0) ? int'((t >> (2 * l)) & 64'h3) : 2;
   endfunction

   function automatic int win_of(int k, int l);
      longint t = 64'h101010101010;
      return (k == 0) ? int'((t >> (8 * l)) & 64'hFF) : 16;
   endfunction

   function automatic mst_t m_reset();
      mst_t r;
      r.ph = PH_IDLE; r.cnt = 0; r.idx = 0; r.P = 0; r.S = 0; r.ovf = 1'b0;
      return r;
   endfunction

   function automatic mst_t mstep(int k, mst_t m, bit st, bit pe, bit vd);
      mst_t n = m;
      bit full = (m.cnt == win_of(k, m.idx));
      case (m.ph)
         PH_IDLE: begin
            if (vd) n.ovf = 1'b1;
            if (st) begin
               n.ph = PH_LOAD; n.idx = 0; n.ovf = 1'b0; n.cnt = 0;
               n.P = p_of(k, 0); n.S = s_of(k, 0);
            end
         end
         PH_LOAD: begin
            if (vd) n.ovf = 1'b1;
            n.ph = PH_CAL;
         end
         PH_CAL: begin
            if (vd) begin
               if (full) n.ovf = 1'b1;
               else      n.cnt = m.cnt + 1;
            end
            if (pe) n.ph = PH_DRAIN;
         end
         PH_DRAIN: begin
            if (full) begin
               if (vd) n.ovf = 1'b1;
               n.ph = PH_LEND;
            end else if (vd) n.cnt = m.cnt + 1;
         end
         PH_LEND: begin
            if (vd) n.ovf = 1'b1;
            if (m.idx == layers(k) - 1) n.ph = PH_DONE;
            else begin
               n.ph = PH_LOAD; n.idx = m.idx + 1; n.cnt = 0;
               n.P = p_of(k, m.idx + 1); n.S = s_of(k, m.idx + 1);
            end
         end
         default: begin
            if (vd) n.ovf = 1'b1;
            n.ph = PH_IDLE;
         end
      endcase
      return n;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ma <= m_reset();
         mb <= m_reset();
      end else begin
         ma <= mstep(0, ma, start0, pe0, vld0);
         mb <= mstep(1, mb, start1, pe1, vld1);
      end
   end

   function automatic logic [31:0] cs_of(int ph);
      case (ph)
         PH_LOAD:  return 32'd1;
         PH_CAL:   return 32'd4;
         PH_DRAIN: return 32'd4;
         PH_LEND:  return 32'd8;
         PH_DONE:  return 32'd9;
         default:  return 32'd0;
      endcase
   endfunction

   // ---------------- checking ----------------
   int n_vec = 0;
   int n_err = 0;
   int n_ld0 = 0;
   int n_nd0 = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic cmp_dut(input int k, input mst_t m, input logic [5:0] cs, input logic [2:0] pp,
                          input logic [1:0] ss, input logic [2:0] ix, input logic ld,
                          input logic nd, input logic bz, input logic ov);
      string t = (k == 0) ? "d0" : "d1";
      chk({t, ".or_cs"},      32'(cs), cs_of(m.ph));
      chk({t, ".P"},          32'(pp), 32'(m.P));
      chk({t, ".S"},          32'(ss), 32'(m.S));
      chk({t, ".layer_idx"},  32'(ix), 32'(m.idx));
      chk({t, ".layer_done"}, 32'(ld), 32'(m.ph == PH_LEND));
      chk({t, ".net_done"},   32'(nd), 32'(m.ph == PH_DONE));
      chk({t, ".busy"},       32'(bz), 32'(m.ph != PH_IDLE));
      chk({t, ".ovf_err"},    32'(ov), 32'(m.ovf));
   endtask

   // One cycle: compare on the falling edge, count pulses, drop pulse inputs.
   task automatic tick();
      @(negedge clk);
      cmp_dut(0, ma, cs0, p0, s0, idx0, ld0, nd0, busy0, ovf0);
      cmp_dut(1, mb, cs1, p1, s1, idx1, ld1, nd1, busy1, ovf1);
      if (ld0) n_ld0++;
      if (nd0) n_nd0++;
      start0 = 1'b0; pe0 = 1'b0; vld0 = 1'b0;
      start1 = 1'b0; pe1 = 1'b0; vld1 = 1'b0;
   endtask

   task automatic wait_cs(input int k, input logic [5:0] v, input string nm);
      int n = 0;
      while ((((k == 0) ? cs0 : cs1) != v) && n < 60) begin
         tick();
         n++;
      end
      chk(nm, 32'((k == 0) ? cs0 : cs1), 32'(v));
   endtask

   int exp_p[6] = '{7, 4, 5, 4, 2, 2};

   initial begin
      rst = 1'b1;
      start0 = 0; pe0 = 0; vld0 = 0; start1 = 0; pe1 = 0; vld1 = 0;
      tick(); tick();
      chk("rst_cs", 32'(cs0), 0);
      chk("rst_busy", 32'(busy0), 0);
      chk("rst_idx", 32'(idx0), 0);
      chk("rst_ovf", 32'(ovf0), 0);
      rst = 1'b0;
      tick();

      // stray window in IDLE, then start clears it
      vld0 = 1'b1;
      tick();
      chk("idle_vld_ovf", 32'(ovf0), 1);
      start0 = 1'b1;
      tick();
      chk("start_clr_ovf", 32'(ovf0), 0);
      chk("lat_load", 32'(cs0), 1);
      tick();
      chk("lat_cal", 32'(cs0), 4);

      // nominal run
      for (int l = 0; l < 6; l++) begin
         wait_cs(0, 6'd4, "wait_cal");
         chk("nom_P", 32'(p0), 32'(exp_p[l]));
         chk("nom_S", 32'(s0), 2);
         chk("nom_idx", 32'(idx0), 32'(l));
         tick();
         pe0 = 1'b1;
         for (int w = 0; w < 16; w++) begin
            tick();
            vld0 = 1'b1;
         end
         wait_cs(0, 6'd8, "wait_lend");
         chk("nom_ld", 32'(ld0), 1);
      end
      tick();
      chk("done_cs", 32'(cs0), 9);
      chk("done_nd", 32'(nd0), 1);
      tick();
      chk("idle_cs", 32'(cs0), 0);
      chk("idle_busy", 32'(busy0), 0);
      chk("hold_P", 32'(p0), 2);
      chk("hold_idx", 32'(idx0), 5);
      chk("ld_count", 32'(n_ld0), 6);
      chk("nd_count", 32'(n_nd0), 1);

      // early drain on layer 0
      start0 = 1'b1;
      wait_cs(0, 6'd4, "early_cal");
      for (int w = 0; w < 16; w++) begin
         tick();
         vld0 = 1'b1;
      end
      tick();
      pe0 = 1'b1;
      tick();
      chk("early_drain", 32'(cs0), 4);
      tick();
      chk("early_lend", 32'(cs0), 8);

      // window coincident with pe_done on layer 1
      wait_cs(0, 6'd4, "coin_cal");
      for (int w = 0; w < 15; w++) begin
         tick();
         vld0 = 1'b1;
      end
      tick();
      vld0 = 1'b1;
      pe0 = 1'b1;
      tick();
      chk("coin_drain", 32'(cs0), 4);
      tick();
      chk("coin_lend", 32'(cs0), 8);

      // start while busy, then overflow on layer 2
      wait_cs(0, 6'd4, "ovf_cal");
      tick();
      start0 = 1'b1;
      tick();
      chk("busy_start_idx", 32'(idx0), 2);
      chk("busy_start_cs", 32'(cs0), 4);
      pe0 = 1'b1;
      for (int w = 0; w < 16; w++) begin
         tick();
         vld0 = 1'b1;
      end
      tick();
      vld0 = 1'b1;
      tick();
      chk("ovf_set", 32'(ovf0), 1);
      chk("ovf_lend", 32'(cs0), 8);

      // sticky into layer 3, then async reset mid-CAL
      wait_cs(0, 6'd4, "l3_cal");
      chk("ovf_sticky", 32'(ovf0), 1);
      chk("l3_idx", 32'(idx0), 3);
      tick(); tick();
      rst = 1'b1;
      #1;
      chk("arst_cs", 32'(cs0), 0);
      chk("arst_busy", 32'(busy0), 0);
      chk("arst_idx", 32'(idx0), 0);
      chk("arst_ovf", 32'(ovf0), 0);
      tick();
      rst = 1'b0;
      tick();

      // single-layer instance
      start1 = 1'b1;
      tick();
      chk("one_load", 32'(cs1), 1);
      wait_cs(1, 6'd4, "one_cal");
      chk("one_P", 32'(p1), 7);
      tick();
      pe1 = 1'b1;
      for (int w = 0; w < 16; w++) begin
         tick();
         vld1 = 1'b1;
      end
      wait_cs(1, 6'd8, "one_lend");
      chk("one_ld", 32'(ld1), 1);
      chk("one_nd0", 32'(nd1), 0);
      tick();
      chk("one_done_cs", 32'(cs1), 9);
      chk("one_nd", 32'(nd1), 1);
      chk("one_ld0", 32'(ld1), 0);
      tick();
      chk("one_idle_cs", 32'(cs1), 0);
      chk("one_idle_busy", 32'(busy1), 0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
